// File: rtl/enemy_spawner_if.sv
// Spawn request channel between the scheduler and the enemy pool.
interface enemy_spawner_if #(
  parameter int X_WIDTH = 10
) ();
  logic               spawn_valid;
  logic               spawn_ready;
  logic [X_WIDTH-1:0] spawn_x;

  modport master (output spawn_valid, output spawn_x, input spawn_ready);
  modport slave  (input spawn_valid, input spawn_x, output spawn_ready);
endinterface

// File: rtl/enemy_spawner.sv
// Wave-based enemy spawn scheduler: tick-paced spawns, LFSR-drawn x coordinate,
// valid/ready handoff to the enemy pool.
module enemy_spawner #(
  parameter int          X_WIDTH   = 10,
  parameter int          X_MIN     = 32,
  parameter int          X_MAX     = 991,
  parameter int          SPAWN_GAP = 3,
  parameter int          WAVE_GAP  = 10,
  parameter int          WAVE_SIZE = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    tick,
  enemy_spawner_if.master         sp,
  output logic [7:0]              wave_num,
  output logic                    wave_done,
  output logic                    busy
);

  localparam int CNT_MAX = (SPAWN_GAP > WAVE_GAP) ? SPAWN_GAP : WAVE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]      WAVE_GAP_C  = CW'(WAVE_GAP);
  localparam logic [CW-1:0]      SPAWN_GAP_C = CW'(SPAWN_GAP);
  localparam logic [CW-1:0]      CNT_ONE     = CW'(1);
  localparam logic [7:0]         LAST_IDX    = 8'(WAVE_SIZE - 1);
  localparam logic [X_WIDTH-1:0] XMIN_C      = X_WIDTH'(X_MIN);
  localparam logic [X_WIDTH-1:0] XMAX_C      = X_WIDTH'(X_MAX);

  typedef enum logic [1:0] {IDLE, GAP, OFFER, SPACE} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [7:0]         spawned, spawned_n;
  logic [7:0]         wave_num_n;
  logic               wave_done_n;
  logic [X_WIDTH-1:0] x_q, x_n;
  logic               valid_q;
  logic [15:0]        lfsr, lfsr_n;
  logic [X_WIDTH-1:0] c, fold_x;
  logic               handshake;

  assign sp.spawn_valid = valid_q;
  assign sp.spawn_x     = x_q;

  // Galois right-shift; feedback applied when the bit shifted out is 1.
  assign lfsr_n = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    c = lfsr[X_WIDTH-1:0];
    if (c < XMIN_C)      fold_x = c + XMIN_C;
    else if (c > XMAX_C) fold_x = c - XMIN_C;
    else                 fold_x = c;
  end

  assign handshake = valid_q & sp.spawn_ready;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    spawned_n   = spawned;
    wave_num_n  = wave_num;
    wave_done_n = 1'b0;
    x_n         = x_q;
    unique case (state)
      IDLE: begin
        if (enable) begin
          cnt_n     = WAVE_GAP_C;
          spawned_n = '0;
          state_n   = GAP;
        end
      end
      GAP, SPACE: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (tick) begin
          if (cnt == CNT_ONE) begin
            x_n     = fold_x;
            state_n = OFFER;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
      end
      OFFER: begin
        // The request is never withdrawn; enable only picks where we go after it.
        if (handshake) begin
          if (spawned == LAST_IDX) begin
            wave_done_n = 1'b1;
            if (wave_num != 8'hFF) wave_num_n = wave_num + 8'd1;
            spawned_n = '0;
            cnt_n     = WAVE_GAP_C;
            state_n   = enable ? GAP : IDLE;
          end else begin
            spawned_n = spawned + 8'd1;
            cnt_n     = SPAWN_GAP_C;
            state_n   = enable ? SPACE : IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      spawned   <= '0;
      wave_num  <= '0;
      wave_done <= 1'b0;
      x_q       <= '0;
      valid_q   <= 1'b0;
      busy      <= 1'b0;
      lfsr      <= LFSR_SEED;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      spawned   <= spawned_n;
      wave_num  <= wave_num_n;
      wave_done <= wave_done_n;
      x_q       <= x_n;
      valid_q   <= (state_n == OFFER);
      busy      <= (state_n != IDLE);
      lfsr      <= lfsr_n;
    end
  end

endmodule

// File: doc/enemy_spawner.md
# enemy_spawner

Wave-based enemy spawn scheduler. It consumes the one-cycle tick pulses produced by the game's timer cluster. It counts ticks to pace spawns inside a wave and the pauses between waves, and draws a pseudo-random horizontal start coordinate for each enemy. Each spawn request goes to the enemy pool through a valid/ready handshake.

## Interface
Parameters:
- `X_WIDTH`, 10: width of the spawn coordinate.
- `X_MIN`, 32: lowest legal spawn x.
- `X_MAX`, 991: highest legal spawn x. Constraints: 2·X_MIN−1 ≤ X_MAX and X_MIN+X_MAX ≥ 2^X_WIDTH−1.
- `SPAWN_GAP`, 3: ticks between consecutive spawns inside a wave. Must be ≥1.
- `WAVE_GAP`, 10: ticks before the first spawn, and between waves. Must be ≥1.
- `WAVE_SIZE`, 8: enemies per wave, range 1..255.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- `clk` in 1: system clock; all logic is on this single clock.
- `rst` in 1: synchronous, active-low reset.
- `enable` in 1: game running; level-sensitive.
- `tick` in 1: one-cycle pulse from the timer cluster; this is the pacing unit.
- `spawn_valid` out 1: spawn request valid.
- `spawn_ready` in 1: enemy pool accepts the request.
- `spawn_x` out X_WIDTH: start coordinate; stable while spawn_valid is high.
- `wave_num` out 8: number of completed waves; saturates at 255.
- `wave_done` out 1: one-cycle pulse when the last enemy of a wave is accepted.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400). It shifts right every cycle, including in IDLE, and is loaded with LFSR_SEED when rst=0.
- Fold, with c = lfsr[X_WIDTH-1:0]:
  - c < X_MIN → x = c + X_MIN
  - c > X_MAX → x = c − X_MIN
  - otherwise x = c
  - The result is always inside [X_MIN, X_MAX].
- Registers:
  - `cnt`: tick countdown, wide enough for max(SPAWN_GAP, WAVE_GAP).
  - `spawned`: 8-bit count of enemies accepted in the current wave.
- States: IDLE, GAP, OFFER, SPACE.
  - IDLE: outputs idle. When enable=1, load cnt=WAVE_GAP, clear spawned, go to GAP.
  - GAP and SPACE:
    - If enable=0, go to IDLE.
    - Else, on tick with cnt==1: register spawn_x = fold(lfsr of this cycle) and go to OFFER.
    - Else, on tick: cnt−1.
    - Ticks are ignored in all other states.
  - OFFER: spawn_valid=1 and spawn_x held. On spawn_valid & spawn_ready:
    - If spawned == WAVE_SIZE−1: pulse wave_done, increment wave_num (saturating), clear spawned, load cnt=WAVE_GAP, go to GAP.
    - Otherwise: spawned+1, load cnt=SPAWN_GAP, go to SPACE.
  - enable=0 in OFFER does not withdraw the request. The handshake completes first. After it, the block goes to IDLE instead of GAP or SPACE, but still applies the wave_done and wave_num update if the wave is complete.
- Leaving GAP or SPACE for IDLE abandons the partial wave: spawned is cleared on the next IDLE→GAP transition. wave_num is kept.

## Timing
- Reset values: state=IDLE, spawn_valid=0, spawn_x=0, wave_num=0, wave_done=0, busy=0, cnt=0, spawned=0.
- All outputs are registered.
- The first IDLE→GAP step takes 1 cycle after enable rises. busy rises in that same cycle.
- spawn_valid rises on the cycle after the Nth tick seen in GAP or SPACE, where N = WAVE_GAP or SPAWN_GAP.
- spawn_valid falls on the cycle after the handshake. A tick in the handshake cycle is not counted.
- Ticks on back-to-back cycles are each counted.
- A stalled handshake (spawn_ready held low) holds OFFER indefinitely. Ticks arriving during the stall are discarded, not queued.
- wave_done is high for exactly the one cycle after the final handshake. wave_num updates in that same cycle.
- rst=0 mid-operation returns to reset values on the next edge, even if spawn_valid was high.

## Test plan
- Reset, enable=1, tick every 5 cycles, spawn_ready=1, WAVE_SIZE=8 → first spawn_valid on the cycle after the 10th tick, then one spawn per 3 ticks. After the 8th accept: wave_done pulses once and wave_num=1; the next spawn comes after 10 more ticks.
- Fold check: force c=5 → 37; c=500 → 500; c=1000 → 968; c=991 → 991; c=31 → 63. Every spawn_x over a 2000-spawn run lies in [32, 991].
- Backpressure: hold spawn_ready=0 for 40 cycles in OFFER with ticks arriving → spawn_valid stays high and spawn_x stays stable. After ready rises, the next spawn needs a full 3 new ticks.
- enable drops during SPACE with spawned=4 → IDLE next cycle with busy=0. Re-enable → a full 10-tick WAVE_GAP, then a wave of 8.
- enable drops during OFFER of the 8th enemy → request held until accepted, then wave_done pulses, wave_num increments, state goes to IDLE.
- WAVE_SIZE=1 and wave_num at 255 → wave_done still pulses and wave_num stays 255. rst=0 asserted while spawn_valid=1 → all outputs at reset values on the next cycle.
